// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch stage.
package fetch_pkg;

  localparam int unsigned DEFAULT_PC_WIDTH    = 32;
  localparam int unsigned DEFAULT_INSTR_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC    = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register: redirect load takes priority over sequential increment.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned                 PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]         RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned                 PC_STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the pc, fetches over req/ack and presents (pc, instruction, valid).
// Optional performance counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int unsigned         INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned         PC_STEP     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [PC_WIDTH-1:0]    i_redirect_pc,
  output logic                   o_imem_req,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_data,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic                   o_valid,
  output logic [31:0]            o_fetch_count,
  output logic [31:0]            o_stall_count
);

  fetch_state_t        state, state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] drain_addr;
  logic                pc_load, pc_inc, capture, clear_valid;

  fetch_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .load_pc (i_redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_comb begin
    state_next  = state;
    o_imem_req  = 1'b0;
    o_imem_addr = pc;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
        pc_load    = i_redirect;
      end
      FETCH: begin
        // Withhold the request while a presented word is stalled so no ack can overwrite it.
        o_imem_req = !(o_valid && i_stall);
        if (i_redirect) begin
          pc_load     = 1'b1;
          clear_valid = 1'b1;
          if (o_imem_req && !i_imem_ack) state_next = DRAIN;
        end else if (!o_imem_req) begin
          state_next = HOLD;
        end else if (i_imem_ack) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
        end else if (!i_stall) begin
          clear_valid = 1'b1;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          pc_load     = 1'b1;
          clear_valid = 1'b1;
          state_next  = FETCH;
        end else if (!i_stall) begin
          clear_valid = 1'b1;
          state_next  = FETCH;
        end
      end
      DRAIN: begin
        o_imem_req  = 1'b1;
        o_imem_addr = drain_addr;
        if (i_redirect) begin
          pc_load     = 1'b1;
          clear_valid = 1'b1;
        end
        if (i_imem_ack) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      drain_addr    <= '0;
      o_pc          <= '0;
      o_instruction <= '0;
      o_valid       <= 1'b0;
    end else begin
      state <= state_next;
      // Tracks the outstanding address so DRAIN can keep it after pc is redirected.
      if (state == FETCH) drain_addr <= pc;
      if (capture) begin
        o_pc          <= pc;
        o_instruction <= i_imem_data;
        o_valid       <= 1'b1;
      end else if (clear_valid) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (capture) fetch_count <= fetch_count + 32'd1;
      if (o_valid && i_stall) stall_count <= stall_count + 32'd1;
    end
  end

  assign o_fetch_count = fetch_count;
  assign o_stall_count = stall_count;
`else
  assign o_fetch_count = '0;
  assign o_stall_count = '0;
`endif

endmodule
